// File: rtl/prog_loader.sv
// prog_loader: receives a little-endian byte stream, packs it into 32-bit
// words and writes them to program memory while holding the core in reset.
// Optional trailing checksum byte: define PROG_LOADER_CHECKSUM_EN.
//
// Stream handshake: a byte transfers on a rising edge where i_s_valid and
// o_s_ready are both 1. o_s_ready depends only on the FSM state, never on
// i_s_valid. The sender may drop i_s_valid at any time; gaps simply stall.
module prog_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_s_valid,
    input  logic [7:0]        i_s_data,
    output logic              o_s_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_core_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // State entered once the last word is written (or immediately for a
    // zero-length load).
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t ST_END = ST_CHECK;
`else
    localparam state_t ST_END = ST_DONE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_idx;
    logic [ADDR_W:0]     w_idx_inc;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                w_start_ok;
    logic                w_data_acc;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    assign w_idx_inc   = r_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign w_data_acc  = (r_state == ST_RECV) && i_s_valid;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_state     = r_state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_next       = r_state;
        w_start_ok   = 1'b0;
        o_s_ready    = 1'b0;
        o_mem_we     = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_core_rst_n = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (r_state == ST_DONE) begin
                    o_done = 1'b1;
                    // Core goes back into reset in the very cycle a new
                    // load is accepted.
                    o_core_rst_n = !i_start;
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                if (r_state == ST_ERROR) begin
                    o_err = 1'b1;
                end
`endif
                if (i_start) begin
                    w_start_ok = 1'b1;
                    if (i_word_count == '0) begin
                        w_next = ST_END;
                    end else begin
                        w_next = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                o_s_ready = 1'b1;
                o_busy    = 1'b1;
                if (i_s_valid && (r_byte_cnt == 2'd3)) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                o_mem_we = 1'b1;
                o_busy   = 1'b1;
                if (w_idx_inc == r_count) begin
                    w_next = ST_END;
                end else begin
                    w_next = ST_RECV;
                end
            end
            ST_CHECK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                o_s_ready = 1'b1;
                o_busy    = 1'b1;
                if (i_s_valid) begin
                    if (i_s_data == r_csum) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_ERROR;
                    end
                end
`else
                w_next = ST_IDLE;
`endif
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: load parameters on start, assemble bytes, advance word index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 24'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum      <= 8'd0;
`endif
        end else begin
            if (w_start_ok) begin
                r_count    <= i_word_count;
                r_idx      <= '0;
                r_byte_cnt <= 2'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_csum     <= 8'd0;
`endif
            end
            if (w_data_acc) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_csum     <= r_csum ^ i_s_data;
`endif
                case (r_byte_cnt)
                    2'd0: r_shift[7:0]   <= i_s_data;
                    2'd1: r_shift[15:8]  <= i_s_data;
                    2'd2: r_shift[23:16] <= i_s_data;
                    default: begin
                        // Completed word is published only here, so the
                        // memory outputs hold steady between writes.
                        r_mem_wdata <= {i_s_data, r_shift};
                        r_mem_addr  <= r_idx[ADDR_W-1:0];
                    end
                endcase
            end
            if (r_state == ST_WRITE) begin
                r_idx <= w_idx_inc;
            end
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, default 6, word-address width of program memory (depth 2^ADDR_W words of 32 bits).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to begin a load; sampled only in IDLE, DONE or ERROR.
REQ-005 word_count  input  ADDR_W+1  number of 32-bit words to load; sampled on the cycle start is accepted.
REQ-006 s_valid  input  1  byte-stream valid.
REQ-007 s_data  input  8  byte-stream data.
REQ-008 s_ready  output  1  byte-stream ready; a byte transfers on a cycle where s_valid and s_ready are both 1.
REQ-009 mem_we  output  1  program-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  ADDR_W  program-memory word address.
REQ-011 mem_wdata  output  32  program-memory write data.
REQ-012 core_rst_n  output  1  active-low reset driven to the core; low while loading.
REQ-013 busy  output  1  high in RECV, WRITE and CHECK.
REQ-014 done  output  1  high in DONE.
REQ-015 err  output  1  high in ERROR.

Function
REQ-016 FSM states: IDLE, RECV, WRITE, CHECK, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR + start: latch word_count, clear address counter, byte counter and checksum; next state RECV, or DONE if word_count = 0 (CHECK if CHECKSUM_EN).
REQ-018 start while busy is ignored.
REQ-019 s_ready = 1 only in RECV and CHECK.
REQ-020 Bytes assemble little-endian: 1st accepted byte to mem_wdata[7:0], 4th to [31:24].
REQ-021 On acceptance of the 4th byte, next state WRITE; in WRITE, mem_we = 1 for exactly one cycle with mem_addr = current word index.
REQ-022 After WRITE: word index increments; if index = latched word_count, go to DONE (CHECK if CHECKSUM_EN), else RECV.
REQ-023 Latency: minimum 5 cycles per word (4 byte beats + 1 write); s_valid gaps stall without loss.
REQ-024 mem_we = 0 in every state other than WRITE; mem_addr and mem_wdata hold their last values otherwise.
REQ-025 word_count > 2^ADDR_W: mem_addr wraps modulo 2^ADDR_W; loading continues until count reached.
REQ-026 core_rst_n = 1 only in DONE; drops to 0 in the same cycle a new start is accepted from DONE.
REQ-027 done and err are mutually exclusive and persist until the next accepted start or rst_n.

Reset
REQ-028 rst_n low forces immediately: state IDLE, s_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_rst_n 0, busy 0, done 0, err 0, all counters and checksum 0.
REQ-029 rst_n asserted mid-load aborts the load; partial words are discarded and are never written.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN compiles in a trailing checksum byte.
REQ-031 With macro: checksum = XOR of all data bytes; CHECK accepts one byte; equal -> DONE, unequal -> ERROR (core_rst_n stays 0, err 1).
REQ-032 Without macro: CHECK and ERROR are unreachable, WRITE of the last word goes straight to DONE, err is constant 0.

Verification
REQ-033 Reset then start with word_count=1, bytes 13,00,00,00 -> one mem_we at addr 0, data 0x00000013; then done=1, core_rst_n=1.
REQ-034 word_count=2, bytes with s_valid toggling every other cycle -> writes 0x00500093@0 and 0x00A00113@1, none lost or duplicated.
REQ-035 start with word_count=0 -> DONE after one cycle (macro off), no mem_we pulse.
REQ-036 rst_n low after 2 bytes of word 0 -> all outputs at reset values, no mem_we; a subsequent full load is correct.
REQ-037 Macro on, 1 word AA,BB,CC,DD + checksum 0x00 -> DONE; repeated with checksum 0x01 -> err=1, core_rst_n=0.
REQ-038 start pulsed during RECV -> ignored, load completes with original word_count.
